// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants for if_fetch (`Zero, widths, FSM states, stall_signal bit indices)
`ifndef IF_FETCH_PKG_DEFS
`define IF_FETCH_PKG_DEFS
`define Zero 32'h0
`endif
package if_fetch_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int STALL_W = 5;
  localparam int STALL_IF = 0;
  typedef enum logic [1:0] {IDLE, FETCH, READY} fetch_state_e;
endpackage

// File: rtl/if_icache.sv
// if_icache: direct-mapped one-word-line icache; ports clk/rst, rd_addr->hit/rd_inst lookup, fill_en/fill_addr/fill_inst write
module if_icache import if_fetch_pkg::*; #(
  parameter int INDEX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              hit,
  output logic [INST_W-1:0] rd_inst,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [INST_W-1:0] fill_inst
);
  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [INST_W-1:0] data [LINES];
  logic [INDEX_W-1:0] rd_idx, fill_idx;
  logic unused_lsb;
  assign unused_lsb = ^{rd_addr[1:0], fill_addr[1:0]};
  assign rd_idx = rd_addr[INDEX_W+1:2];
  assign fill_idx = fill_addr[INDEX_W+1:2];
  assign hit = valid[rd_idx] && tags[rd_idx] == rd_addr[ADDR_W-1:INDEX_W+2];
  assign rd_inst = data[rd_idx];
  always_ff @(posedge clk)
    if (rst) valid <= '0;
    else if (fill_en) valid[fill_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (fill_en) begin
      tags[fill_idx] <= fill_addr[ADDR_W-1:INDEX_W+2];
      data[fill_idx] <= fill_inst;
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: IF stage fetching 32-bit insts as 4 byte reads (mem_req_o/mem_addr_o/mem_busy_i/mem_data_i) into pc_o/inst_o, with stall_signal, jump_flag/jump_addr, if_stall_req_o; ICACHE_EN adds if_icache
module if_fetch import if_fetch_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
`ifdef ICACHE_EN
  , parameter int ICACHE_INDEX_W = 7
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_signal,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_busy_i,
  input  logic [7:0]         mem_data_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INST_W-1:0]  inst_o,
  output logic               if_stall_req_o
);
  fetch_state_e state;
  logic [ADDR_W-1:0] pc;
  logic [2:0] iss;
  logic [1:0] rcv;
  logic in_flight;
  logic [23:0] lo;
  logic hit, use_hit, done, accept;
  logic [INST_W-1:0] hit_inst, fetched;
  logic unused_stall;
  assign unused_stall = ^stall_signal[STALL_W-1:1];
  assign use_hit = state == FETCH && iss == 3'd0 && hit;
  assign mem_req_o = state == FETCH && !iss[2] && !use_hit;
  assign mem_addr_o = pc + {29'd0, iss};
  assign accept = mem_req_o && !mem_busy_i;
  assign done = state == FETCH && in_flight && rcv == 2'd3;
  assign fetched = {mem_data_i, lo};
  assign if_stall_req_o = state != READY;
`ifdef ICACHE_EN
  if_icache #(.INDEX_W(ICACHE_INDEX_W)) u_icache (
    .clk(clk),
    .rst(rst),
    .rd_addr(pc),
    .hit(hit),
    .rd_inst(hit_inst),
    .fill_en(done),
    .fill_addr(pc),
    .fill_inst(fetched)
  );
`else
  assign hit = 1'b0;
  assign hit_inst = `Zero;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pc_o <= `Zero;
      inst_o <= `Zero;
      iss <= 3'd0;
      rcv <= 2'd0;
      in_flight <= 1'b0;
      lo <= 24'd0;
    end else if (jump_flag) begin
      state <= FETCH;
      pc <= jump_addr;
      pc_o <= `Zero;
      inst_o <= `Zero;
      iss <= 3'd0;
      rcv <= 2'd0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= accept;
      if (state == IDLE) state <= FETCH;
      else if (state == READY) begin
        if (!stall_signal[STALL_IF]) begin
          state <= FETCH;
          pc <= pc + 32'd4;
          pc_o <= `Zero;
          inst_o <= `Zero;
          iss <= 3'd0;
          rcv <= 2'd0;
        end
      end else begin
        if (accept) iss <= iss + 3'd1;
        if (in_flight) begin
          lo <= {mem_data_i, lo[23:8]};
          rcv <= rcv + 2'd1;
        end
        if (use_hit || done) begin
          state <= READY;
          pc_o <= pc;
          inst_o <= use_hit ? hit_inst : fetched;
        end
      end
    end
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that feeds the IF/ID pipeline register.
- Owns the PC and fetches each 32-bit instruction as four byte reads from the shared byte-wide memory controller.
- Assembles the bytes little-endian and presents pc/inst to IF/ID.
- Honours pipeline stall and branch/jump redirect; raises a stall request while an instruction is not ready.

Parameters:
- RESET_PC, 32'h0, PC value after reset.
- ICACHE_INDEX_W, 7, log2 of icache lines; used only with ICACHE_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_signal  in  5  pipeline stall vector; bit[0]=hold IF (do not consume presented inst)
- jump_flag  in  1  redirect request from EX
- jump_addr  in  32  redirect target
- mem_req_o  out  1  byte-read request
- mem_addr_o  out  32  byte address
- mem_busy_i  in  1  controller serving another master; request not accepted this cycle
- mem_data_i  in  8  read byte, valid exactly one cycle after an accepted request
- pc_o  out  32  PC of presented instruction (to if_id pc_i)
- inst_o  out  32  presented instruction (to if_id inst_i)
- if_stall_req_o  out  1  high while no valid instruction is presented

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, pc_o=0, inst_o=0, mem_req_o=0, byte counters=0, in-flight flag=0, state=IDLE.
  - Reset mid-fetch discards all partial data.
- States:
  - IDLE: one cycle after reset, then goes to FETCH.
  - FETCH: issue/collect bytes.
  - READY: instruction presented.
- FETCH, issuing:
  - issue counter iss (0..3); mem_req_o=1 and mem_addr_o=pc+iss while iss<4.
  - Accepted when mem_busy_i=0, then iss++.
  - While mem_busy_i=1, hold address and request.
- FETCH, collecting:
  - in-flight flag is set the cycle after an acceptance.
  - Capture mem_data_i into byte lane rcv, then rcv++.
  - When rcv reaches 4: inst_o={b3,b2,b1,b0}, pc_o=pc, go to READY.
- Timing:
  - No-contention latency: 4 requests in cycles 0–3, bytes captured in cycles 1–4, inst_o valid from cycle 5.
- READY:
  - if_stall_req_o=0; mem_req_o=0.
  - If stall_signal[0]=0, the instruction is consumed: pc+=4, go to FETCH next cycle.
  - If stall_signal[0]=1, pc_o/inst_o hold.
- FETCH/IDLE outputs:
  - pc_o=0 and inst_o=0, presenting a bubble.
  - if_stall_req_o=1.
- PC arithmetic: pc+iss and pc+4 wrap modulo 2^32.
- jump_flag (priority over everything except rst):
  - pc=jump_addr, counters cleared, pc_o/inst_o cleared, state=FETCH next cycle.
  - A byte in flight from the cancelled fetch arrives the next cycle and is dropped.
  - Jump coinciding with consumption: jump wins and no pc+4 is applied.
  - Jump while stalled: still redirects.
- mem_busy_i never drops an in-flight byte; data returns regardless of busy.

Optional Feature:
- Macro: ICACHE_EN.
- With ICACHE_EN: direct-mapped instruction cache of 2^ICACHE_INDEX_W one-word lines.
  - index=pc[ICACHE_INDEX_W+1:2], tag=pc[31:ICACHE_INDEX_W+2], per-line valid bit.
  - On FETCH entry, a hit presents inst_o in READY on the next cycle with no memory request.
  - A miss performs the byte fetch and fills the line on completion.
  - Reset clears all valid bits; jump does not invalidate.
- Without ICACHE_EN: no arrays; every fetch goes to memory.

Decomposition:
- Shared define/package holds:
  - zero constant (`Zero), instruction and address widths.
  - FSM state encodings (IDLE/FETCH/READY).
  - stall_signal bit indices.
- One natural sub-module: if_icache (lookup/fill arrays), instantiated only under ICACHE_EN.

Test Plan:
1. Reset, then memory bytes at 0..3 = 13 05 10 00 → cycle 5 after FETCH entry: pc_o=0, inst_o=0x00100513, if_stall_req_o=0; next instruction fetched from address 4.
2. mem_busy_i=1 for 3 cycles during iss=2 → mem_addr_o held at 0x2; instruction presented 3 cycles later than case 1 with correct value.
3. jump_flag with jump_addr=0x100 after 2 bytes received → stale byte dropped, next requests at 0x100..0x103, pc_o=0x100.
4. stall_signal[0]=1 for 4 cycles in READY → pc_o/inst_o unchanged and no mem_req_o; after release, the fetch at pc+4 begins the next cycle.
5. jump_flag and consumption in the same cycle → pc=jump_addr, not pc+4.
6. (ICACHE_EN) loop 0x0→0x4→jump 0x0 → second visit to 0x0 presents inst 1 cycle after FETCH entry, with mem_req_o never asserted.
